// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute stage wrapping the ALU, feeding writeback.
//
// Decoded ops arrive over a valid/ready handshake. Each one is evaluated by the
// ALU against the architectural NZVC register in the same cycle it is accepted.
// The result goes into a two-entry output queue (head + skid), so in_ready can
// come straight from a flop.
//
// Optional feature macro: ALU_EXEC_PERF_CNT_EN adds perf_ops / perf_stalls.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready upstream handshake (in_ready registered)
//   in_oper, in_a, in_b, in_dest, in_set_flags  decoded operation
//   flush             synchronous flush: empties the queue, drops same-cycle accept
//   flags_wr_en/flags_wr_data  direct NZVC write (wins over an accept commit)
//   flags             architectural NZVC register {N,Z,V,C}
//   out_valid/out_ready downstream handshake for the head entry
//   out_result, out_dest, out_flags  head entry contents
//   perf_ops, perf_stalls  (ALU_EXEC_PERF_CNT_EN only) saturating counters
//
// Opcodes: 0 Add, 1 Adc, 2 Sub, 3 Sbc, 4 Rsb, 5 Mul, 6 And, 7 Or, 8 Xor,
//          9 Lsl, 10 Lsr, 11 Asr, 12 Rol, 13 Ror, 14 Rlc, 15 Rrc.
// Subtract-type ops use carry = NOT borrow. Shifts/rotates use the low
// log2(WORD_WIDTH) bits of b as the amount; an amount of 0 leaves C alone.
module alu_exec_stage #(
  parameter int WORD_WIDTH    = 32,
  parameter int REG_IDX_WIDTH = 4,
  parameter int OPER_WIDTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPER_WIDTH-1:0]    in_oper,
  input  logic [WORD_WIDTH-1:0]    in_a,
  input  logic [WORD_WIDTH-1:0]    in_b,
  input  logic [REG_IDX_WIDTH-1:0] in_dest,
  input  logic                     in_set_flags,
  input  logic                     flush,
  input  logic                     flags_wr_en,
  input  logic [3:0]               flags_wr_data,
  output logic [3:0]               flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_WIDTH-1:0]    out_result,
  output logic [REG_IDX_WIDTH-1:0] out_dest,
  output logic [3:0]               out_flags
`ifdef ALU_EXEC_PERF_CNT_EN
  ,
  output logic [31:0]              perf_ops,
  output logic [31:0]              perf_stalls
`endif
);

  localparam int MSB = WORD_WIDTH - 1;
  localparam int SHW = $clog2(WORD_WIDTH);

  // Flag bit positions within {N,Z,V,C}
  localparam int FN = 3;
  localparam int FZ = 2;
  localparam int FV = 1;
  localparam int FC = 0;

  localparam logic [OPER_WIDTH-1:0] OP_ADD = OPER_WIDTH'(0);
  localparam logic [OPER_WIDTH-1:0] OP_ADC = OPER_WIDTH'(1);
  localparam logic [OPER_WIDTH-1:0] OP_SUB = OPER_WIDTH'(2);
  localparam logic [OPER_WIDTH-1:0] OP_SBC = OPER_WIDTH'(3);
  localparam logic [OPER_WIDTH-1:0] OP_RSB = OPER_WIDTH'(4);
  localparam logic [OPER_WIDTH-1:0] OP_MUL = OPER_WIDTH'(5);
  localparam logic [OPER_WIDTH-1:0] OP_AND = OPER_WIDTH'(6);
  localparam logic [OPER_WIDTH-1:0] OP_OR  = OPER_WIDTH'(7);
  localparam logic [OPER_WIDTH-1:0] OP_XOR = OPER_WIDTH'(8);
  localparam logic [OPER_WIDTH-1:0] OP_LSL = OPER_WIDTH'(9);
  localparam logic [OPER_WIDTH-1:0] OP_LSR = OPER_WIDTH'(10);
  localparam logic [OPER_WIDTH-1:0] OP_ASR = OPER_WIDTH'(11);
  localparam logic [OPER_WIDTH-1:0] OP_ROL = OPER_WIDTH'(12);
  localparam logic [OPER_WIDTH-1:0] OP_ROR = OPER_WIDTH'(13);
  localparam logic [OPER_WIDTH-1:0] OP_RLC = OPER_WIDTH'(14);
  localparam logic [OPER_WIDTH-1:0] OP_RRC = OPER_WIDTH'(15);

  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } q_state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  q_state_t                 q_state_r, q_cand_s, q_next_s;
  logic                     in_ready_r, out_valid_r;
  logic [3:0]               flags_r;
  logic [WORD_WIDTH-1:0]    head_result_r, skid_result_r;
  logic [REG_IDX_WIDTH-1:0] head_dest_r, skid_dest_r;
  logic [3:0]               head_flags_r, skid_flags_r;

  logic accept_s, pop_s;
  logic load_head_new_s, load_skid_new_s, load_head_skid_s;

  // ---------------------------------------------------------------------------
  // ALU datapath
  // ---------------------------------------------------------------------------
  logic                       c_in_s;
  logic [WORD_WIDTH-1:0]      add_x_s, add_y_s;
  logic                       add_cin_s;
  logic [WORD_WIDTH:0]        add_sum_s;
  logic                       add_ovf_s;
  logic [WORD_WIDTH-1:0]      mul_s;
  logic [SHW-1:0]             sh_s, sh_rev_s;
  logic                       sh_zero_s;
  logic [WORD_WIDTH:0]        lsl_wide_s, lsr_wide_s;
  logic signed [WORD_WIDTH:0] asr_wide_s;
  logic [WORD_WIDTH-1:0]      rol_s, ror_s;
  logic [WORD_WIDTH-1:0]      alu_result_s;
  logic [3:0]                 alu_flags_s;
  logic                       alu_op_ok_s;

  assign c_in_s = flags_r[FC];

  // Adder operand selection: every subtract form is x + ~y + carry-in
  always_comb begin
    add_x_s   = in_a;
    add_y_s   = in_b;
    add_cin_s = 1'b0;
    case (in_oper)
      OP_ADC: add_cin_s = c_in_s;
      OP_SUB: begin
        add_y_s   = ~in_b;
        add_cin_s = 1'b1;
      end
      OP_SBC: begin
        add_y_s   = ~in_b;
        add_cin_s = c_in_s;
      end
      OP_RSB: begin
        add_x_s   = ~in_a;
        add_cin_s = 1'b1;
      end
      default: add_cin_s = 1'b0;
    endcase
  end

  assign add_sum_s = {1'b0, add_x_s} + {1'b0, add_y_s} + {{WORD_WIDTH{1'b0}}, add_cin_s};
  // Signed overflow: both addends share a sign that the sum does not
  assign add_ovf_s = (add_x_s[MSB] == add_y_s[MSB]) && (add_sum_s[MSB] != add_x_s[MSB]);
  assign mul_s     = in_a * in_b;

  // Shifters carry one extra bit so the last bit shifted out lands in C
  assign sh_s       = in_b[SHW-1:0];
  assign sh_zero_s  = (sh_s == {SHW{1'b0}});
  assign sh_rev_s   = {SHW{1'b0}} - sh_s;
  assign lsl_wide_s = {1'b0, in_a} << sh_s;
  assign lsr_wide_s = {in_a, 1'b0} >> sh_s;
  assign asr_wide_s = $signed({in_a, 1'b0}) >>> sh_s;
  // With amount 0 the complementary shift is also 0, so both terms equal a
  assign rol_s      = (in_a << sh_s) | (in_a >> sh_rev_s);
  assign ror_s      = (in_a >> sh_s) | (in_a << sh_rev_s);

  // Result and flag selection; V and C pass through unless the op defines them
  always_comb begin
    alu_result_s = {WORD_WIDTH{1'b0}};
    alu_flags_s  = flags_r;
    alu_op_ok_s  = 1'b1;
    case (in_oper)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_RSB: begin
        alu_result_s    = add_sum_s[MSB:0];
        alu_flags_s[FC] = add_sum_s[WORD_WIDTH];
        alu_flags_s[FV] = add_ovf_s;
      end
      OP_MUL: alu_result_s = mul_s;
      OP_AND: alu_result_s = in_a & in_b;
      OP_OR:  alu_result_s = in_a | in_b;
      OP_XOR: alu_result_s = in_a ^ in_b;
      OP_LSL: begin
        alu_result_s    = lsl_wide_s[MSB:0];
        alu_flags_s[FC] = sh_zero_s ? c_in_s : lsl_wide_s[WORD_WIDTH];
      end
      OP_LSR: begin
        alu_result_s    = lsr_wide_s[WORD_WIDTH:1];
        alu_flags_s[FC] = sh_zero_s ? c_in_s : lsr_wide_s[0];
      end
      OP_ASR: begin
        alu_result_s    = asr_wide_s[WORD_WIDTH:1];
        alu_flags_s[FC] = sh_zero_s ? c_in_s : asr_wide_s[0];
      end
      OP_ROL: begin
        alu_result_s    = rol_s;
        alu_flags_s[FC] = sh_zero_s ? c_in_s : rol_s[0];
      end
      OP_ROR: begin
        alu_result_s    = ror_s;
        alu_flags_s[FC] = sh_zero_s ? c_in_s : ror_s[MSB];
      end
      OP_RLC: begin
        alu_result_s    = {in_a[MSB-1:0], c_in_s};
        alu_flags_s[FC] = in_a[MSB];
      end
      OP_RRC: begin
        alu_result_s    = {c_in_s, in_a[MSB:1]};
        alu_flags_s[FC] = in_a[0];
      end
      default: alu_op_ok_s = 1'b0;
    endcase
    if (alu_op_ok_s) begin
      alu_flags_s[FN] = alu_result_s[MSB];
      alu_flags_s[FZ] = (alu_result_s == {WORD_WIDTH{1'b0}});
    end else begin
      alu_result_s = {WORD_WIDTH{1'b0}};
      alu_flags_s  = flags_r;
    end
  end

  // ---------------------------------------------------------------------------
  // Output queue control
  // ---------------------------------------------------------------------------
  assign accept_s = in_valid & in_ready_r & ~flush;
  assign pop_s    = out_valid_r & out_ready;

  // Queue next-state and entry load selects
  always_comb begin
    q_cand_s         = q_state_r;
    load_head_new_s  = 1'b0;
    load_skid_new_s  = 1'b0;
    load_head_skid_s = 1'b0;
    case (q_state_r)
      Q_EMPTY: begin
        if (accept_s) begin
          q_cand_s        = Q_ONE;
          load_head_new_s = 1'b1;
        end else begin
          q_cand_s = Q_EMPTY;
        end
      end
      Q_ONE: begin
        if (accept_s && !pop_s) begin
          q_cand_s        = Q_FULL;
          load_skid_new_s = 1'b1;
        end else if (accept_s && pop_s) begin
          q_cand_s        = Q_ONE;
          load_head_new_s = 1'b1;
        end else if (pop_s) begin
          q_cand_s = Q_EMPTY;
        end else begin
          q_cand_s = Q_ONE;
        end
      end
      Q_FULL: begin
        if (pop_s) begin
          q_cand_s         = Q_ONE;
          load_head_skid_s = 1'b1;
        end else begin
          q_cand_s = Q_FULL;
        end
      end
      default: q_cand_s = Q_EMPTY;
    endcase
    q_next_s = flush ? Q_EMPTY : q_cand_s;
  end

  // Queue state plus handshake flags, both derived from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_state_r   <= Q_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      q_state_r   <= q_next_s;
      in_ready_r  <= (q_next_s != Q_FULL);
      out_valid_r <= (q_next_s != Q_EMPTY);
    end
  end

  // Head and skid entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_result_r <= {WORD_WIDTH{1'b0}};
      head_dest_r   <= {REG_IDX_WIDTH{1'b0}};
      head_flags_r  <= 4'b0000;
      skid_result_r <= {WORD_WIDTH{1'b0}};
      skid_dest_r   <= {REG_IDX_WIDTH{1'b0}};
      skid_flags_r  <= 4'b0000;
    end else begin
      if (load_head_new_s) begin
        head_result_r <= alu_result_s;
        head_dest_r   <= in_dest;
        head_flags_r  <= alu_flags_s;
      end else if (load_head_skid_s) begin
        head_result_r <= skid_result_r;
        head_dest_r   <= skid_dest_r;
        head_flags_r  <= skid_flags_r;
      end
      if (load_skid_new_s) begin
        skid_result_r <= alu_result_s;
        skid_dest_r   <= in_dest;
        skid_flags_r  <= alu_flags_s;
      end
    end
  end

  // Architectural flags: direct write beats an accept commit; flush leaves them alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r <= 4'b0000;
    end else if (flags_wr_en) begin
      flags_r <= flags_wr_data;
    end else if (accept_s && in_set_flags && alu_op_ok_s) begin
      flags_r <= alu_flags_s;
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_result = head_result_r;
  assign out_dest   = head_dest_r;
  assign out_flags  = head_flags_r;
  assign flags      = flags_r;

`ifdef ALU_EXEC_PERF_CNT_EN
  logic [31:0] perf_ops_r, perf_stalls_r;

  // Saturating accept and stall counters, untouched by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops_r    <= 32'd0;
      perf_stalls_r <= 32'd0;
    end else begin
      if (accept_s && (perf_ops_r != 32'hFFFF_FFFF)) begin
        perf_ops_r <= perf_ops_r + 32'd1;
      end
      if (in_valid && !in_ready_r && (perf_stalls_r != 32'hFFFF_FFFF)) begin
        perf_stalls_r <= perf_stalls_r + 32'd1;
      end
    end
  end

  assign perf_ops    = perf_ops_r;
  assign perf_stalls = perf_stalls_r;
`endif

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute pipeline stage directly upstream of writeback, wrapping the project ALU.
- Accepts decoded operations (oper, operands, destination, set-flags bit) over a valid/ready handshake and evaluates them combinationally through the ALU against the architectural flag register.
- Commits NZVC on acceptance and buffers results in a 2-entry output queue (main + skid) so that in_ready is purely registered.

Parameters:
- WORD_WIDTH, 32, operand/result width; power of two.
- REG_IDX_WIDTH, 4, destination register index width.
- OPER_WIDTH, 4, ALU operation code width; codes 0-15 map to Add, Adc, Sub, Sbc, Rsb, Mul, And, Or, Xor, Lsl, Lsr, Asr, Rol, Ror, Rlc, Rrc.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  upstream op valid.
- in_ready  out  1  stage can accept; registered.
- in_oper  in  OPER_WIDTH  ALU operation.
- in_a  in  WORD_WIDTH  operand A.
- in_b  in  WORD_WIDTH  operand B.
- in_dest  in  REG_IDX_WIDTH  destination register.
- in_set_flags  in  1  commit ALU flags for this op.
- flush  in  1  synchronous pipeline flush.
- flags_wr_en  in  1  direct flag register write.
- flags_wr_data  in  4  NZVC value for a direct write.
- flags  out  4  current architectural NZVC register.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_result  out  WORD_WIDTH  head result.
- out_dest  out  REG_IDX_WIDTH  head destination.
- out_flags  out  4  flags produced by the head op (ALU output).

Behaviour:
- Reset: both entries invalid; out_valid=0; in_ready=1; flags=4'b0000; out_result/out_dest/out_flags=0.
- Accept fires when in_valid & in_ready & !flush.
- ALU sees a=in_a, b=in_b, oper=in_oper, flags=current flags register. The result is captured in the entry the same cycle it is accepted, so latency from accept to out_valid is 1 cycle.
- Flag commit on accept when in_set_flags=1: flags <= ALU flags. If in_set_flags=0, flags are unchanged. The next accepted op, even back-to-back (Add then Adc), sees the committed flags.
- Direct write: when flags_wr_en=1, flags <= flags_wr_data. This has priority over a same-cycle accept commit; the accepted op still carries its own ALU flags in out_flags.
- Opcodes outside 0-15 (only possible if OPER_WIDTH > 4): result 0; out_flags = input flags; no flag commit.
- Queue: states EMPTY, ONE, FULL.
  - EMPTY --accept--> ONE.
  - ONE: accept & !pop -> FULL; pop & !accept -> EMPTY; both -> ONE (new entry replaces head).
  - FULL: pop -> ONE (skid moves to head); in_ready=0 in FULL, so there is no accept.
  - pop = out_valid & out_ready.
- in_ready is registered: it is 1 in EMPTY and ONE and 0 in FULL, computed from next state.
- flush: next state EMPTY, out_valid=0 next cycle, any same-cycle accept is dropped, and the flags register is unaffected. Concurrent flags_wr_en still applies.
- Head ordering is strictly FIFO. out_* stay stable while out_valid & !out_ready.
- Reset asserted mid-operation: queue and flags cleared immediately (asynchronous); in_ready=1 after release.

Optional Feature:
- Macro: ALU_EXEC_PERF_CNT_EN.
- When defined, the block adds outputs perf_ops (32 bits) and perf_stalls (32 bits). Both reset to 0 and saturate at 0xFFFFFFFF.
  - perf_ops increments on each accept.
  - perf_stalls increments each cycle with in_valid & !in_ready.
  - flush does not clear either counter.
- When undefined, the ports and counters are absent and the block has no other difference.

Test Plan:
- Back-to-back Add a=0xFFFFFFFF, b=1, set_flags=1, then Adc a=0, b=0, set_flags=1 -> first result 0 with out_flags N=0 Z=1 C=1 V=0; second result 0x00000001, C=0; final flags Z=0 C=0.
- out_ready=0; push Or 0x1|0x2, Xor 0xF^0x3, Sub 5-3 -> first two accepted (0x3, 0xC); in_ready=0 from the cycle after the second accept; raise out_ready -> 0x3, 0xC, then 0x2 with C=1, in order, with no loss.
- Accept Lsl a=1, b=4, set_flags=0 while flags=4'b1010 -> result 0x10; flags remain 4'b1010.
- Same cycle: accept Sub 0-1 with set_flags=1, and flags_wr_en=1 with data 4'b0001 -> flags=4'b0001; that op's out_flags show N=1, C=0.
- Queue FULL, then flush=1 for one cycle together with in_valid -> out_valid=0 and in_ready=1 next cycle; the dropped op never appears; flags unchanged.
- Reset asserted while FULL, then released -> out_valid=0, flags=0, in_ready=1. With ALU_EXEC_PERF_CNT_EN defined, perf_ops=0 and perf_stalls=0 after reset; 3 accepts plus 2 stalled cycles give perf_ops=3 and perf_stalls=2.
